mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 4:1 mux between four requesters. It produces the mux select (s1,s0), a one-hot grant and status flags. Each requester keeps the mux for at most MAX_HOLD consecutive cycles. The block sits directly in front of the mux select inputs, so the mux itself is unchanged.

---
 rtl/mux4_rr_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Round-robin arbiter that drives the select lines of an existing 4:1 mux.
// Four requesters share the mux. Each one keeps it for at most MAX_HOLD
// consecutive cycles before the others get a turn.
//
// Parameters
//   MAX_HOLD   maximum consecutive grant cycles per tenure (1..255)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (async assert, sync release)
//   req[3:0]   request per source; bit i = requester i = mux input i
//   gnt[3:0]   registered one-hot grant, 4'b0000 when idle
//   s1, s0     registered mux select; {s1,s0} = index of current/last owner
//   busy       registered, equals |gnt
//   new_grant  one-cycle pulse on the first cycle of every new tenure
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic       new_grant
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Last cycle value of the hold counter; reaching it ends the tenure.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e     state_q,     state_d;
  logic [1:0] ptr_q,       ptr_d;
  logic [1:0] owner_q,     owner_d;
  logic [3:0] gnt_q,       gnt_d;
  logic       busy_q,      busy_d;
  logic       new_grant_q, new_grant_d;
  logic [7:0] hold_cnt_q,  hold_cnt_d;

  // Search inputs/results.
  logic [3:0] search_req;
  logic       pick_found;
  logic [1:0] pick_idx;
  logic       owner_req;
  logic       win_valid;
  logic [1:0] win_idx;

  // ---------------------------------------------------------------------------
  // Round-robin search: first set bit in order p, p+1, p+2, p+3 (mod 4).
  // Returns {found, index}.
  // ---------------------------------------------------------------------------
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = p + 2'(k);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  // While a grant is active the owner is masked out of the search, so a
  // release or expiry hands over to somebody else whenever anybody else asks.
  assign search_req = (state_q == GRANT) ? (req & ~gnt_q) : req;
  assign {pick_found, pick_idx} = rr_pick(search_req, ptr_q);
  assign owner_req  = |(req & gnt_q);

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; an unassigned path in always_comb would infer a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    gnt_d       = gnt_q;
    busy_d      = busy_q;
    new_grant_d = 1'b0;
    hold_cnt_d  = hold_cnt_q;
    win_valid   = 1'b0;
    win_idx     = owner_q;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          win_valid = 1'b1;
          win_idx   = pick_idx;
        end
      end

      GRANT: begin
        if (owner_req && (hold_cnt_q < HOLD_LAST)) begin
          // Continue the current tenure. New requests never pre-empt.
          hold_cnt_d = hold_cnt_q + 8'd1;
        end else if (pick_found) begin
          // Release or expiry with another requester waiting: hand over on
          // the same edge, no idle bubble.
          win_valid = 1'b1;
          win_idx   = pick_idx;
        end else if (owner_req) begin
          // Expiry with nobody else waiting: re-grant as a fresh tenure.
          win_valid = 1'b1;
          win_idx   = owner_q;
        end else begin
          // Owner released and nobody else asks. The select lines keep the
          // last owner so the mux output stays stable.
          state_d = IDLE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase

    if (win_valid) begin
      state_d     = GRANT;
      owner_d     = win_idx;
      gnt_d       = 4'b0001 << win_idx;
      busy_d      = 1'b1;
      new_grant_d = 1'b1;
      hold_cnt_d  = 8'd0;
      ptr_d       = win_idx + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: reset is asynchronous so asserting rst_n mid-tenure drops the grant
  // at once; every flop here is control state, so all of them are reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      owner_q     <= 2'd0;
      gnt_q       <= 4'b0000;
      busy_q      <= 1'b0;
      new_grant_q <= 1'b0;
      hold_cnt_q  <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      new_grant_q <= new_grant_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign s1        = owner_q[1];
  assign s0        = owner_q[0];
  assign busy      = busy_q;
  assign new_grant = new_grant_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//
// Directed testbench for mux4_rr_arbiter. Two instances share clock, reset and
// requests: dut (MAX_HOLD=4) and dut_h1 (MAX_HOLD=1). Outputs are sampled 1
// time unit after each rising edge and compared against hand-computed vectors
// packed as {gnt, s1, s0, busy, new_grant}.
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;

  logic [3:0] gnt,    gnt_h1;
  logic       s1,     s1_h1;
  logic       s0,     s0_h1;
  logic       busy,   busy_h1;
  logic       new_grant, new_grant_h1;

  int tests_run;
  int tests_failed;

  mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .s1        (s1),
    .s0        (s0),
    .busy      (busy),
    .new_grant (new_grant)
  );

  mux4_rr_arbiter #(.MAX_HOLD(1)) dut_h1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt_h1),
    .s1        (s1_h1),
    .s0        (s0_h1),
    .busy      (busy_h1),
    .new_grant (new_grant_h1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {gnt[3:0], s1, s0, busy, new_grant}
  function automatic logic [7:0] vec(input logic [3:0] g, input logic [1:0] sel,
                                     input logic b, input logic ng);
    return {g, sel, b, ng};
  endfunction

  // Expected vector for an active grant to owner o.
  function automatic logic [7:0] own(input int o, input logic ng);
    logic [1:0] sel;
    logic [3:0] g;
    sel = 2'(o);
    g   = 4'b0001 << sel;
    return {g, sel, 1'b1, ng};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed gnt/s1s0/busy/ng=%b_%b_%b_%b expected %b_%b_%b_%b",
             tag, obs[7:4], obs[3:2], obs[1], obs[0], exp[7:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] obs4();
    return {gnt, s1, s0, busy, new_grant};
  endfunction

  function automatic logic [7:0] obs1();
    return {gnt_h1, s1_h1, s0_h1, busy_h1, new_grant_h1};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    req          = 4'b0000;

    // 1. Reset and idle
    tick();
    tick();
    check("reset", obs4(), vec(4'b0000, 2'd0, 1'b0, 1'b0));
    check("reset_h1", obs1(), vec(4'b0000, 2'd0, 1'b0, 1'b0));
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("idle_c%0d", c), obs4(), vec(4'b0000, 2'd0, 1'b0, 1'b0));
    end

    // 2. Single request held: re-grant on expiry every 4 cycles.
    req = 4'b0100;
    for (int c = 1; c <= 12; c++) begin
      tick();
      check($sformatf("single_c%0d", c), obs4(), own(2, (c == 1) || (c == 5) || (c == 9)));
      check($sformatf("single_h1_c%0d", c), obs1(), own(2, 1'b1));
    end
    req = 4'b0000;
    tick();
    check("single_release", obs4(), vec(4'b0000, 2'd2, 1'b0, 1'b0));

    // 3. All requesting from a fresh pointer.
    do_reset();
    req = 4'b1111;
    for (int c = 1; c <= 20; c++) begin
      tick();
      check($sformatf("all_c%0d", c), obs4(), own(((c - 1) / 4) % 4, ((c - 1) % 4) == 0));
      check($sformatf("all_h1_c%0d", c), obs1(), own((c - 1) % 4, 1'b1));
    end

    // 4. Early release: owner 1 drops after 2 cycles, requester 2 idle, 3 waits.
    do_reset();
    req = 4'b1010;
    tick();
    check("early_grant1", obs4(), own(1, 1'b1));
    tick();
    check("early_hold1", obs4(), own(1, 1'b0));
    req = 4'b1000;
    tick();
    check("early_switch3", obs4(), own(3, 1'b1));
    tick();
    check("early_hold3", obs4(), own(3, 1'b0));

    // 5. Release to idle: hand to 2, then 2 drops with nobody else asking.
    req = 4'b0100;
    tick();
    check("rel_switch2", obs4(), own(2, 1'b1));
    tick();
    check("rel_hold2", obs4(), own(2, 1'b0));
    req = 4'b0000;
    tick();
    check("rel_idle", obs4(), vec(4'b0000, 2'd2, 1'b0, 1'b0));
    tick();
    check("rel_idle2", obs4(), vec(4'b0000, 2'd2, 1'b0, 1'b0));
    req = 4'b0001;
    tick();
    check("rel_regrant0", obs4(), own(0, 1'b1));

    // 6. Async reset mid-tenure.
    req = 4'b0010;
    tick();
    check("arst_grant1", obs4(), own(1, 1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_drop", obs4(), vec(4'b0000, 2'd0, 1'b0, 1'b0));
    req = 4'b1111;
    tick();
    check("arst_held", obs4(), vec(4'b0000, 2'd0, 1'b0, 1'b0));
    rst_n = 1'b1;
    tick();
    check("arst_first0", obs4(), own(0, 1'b1));
    check("arst_first0_h1", obs1(), own(0, 1'b1));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
